// File: rtl/pdp8_pkg.sv
// Shared PDP-8 core definitions: word/address widths and instruction fetch unit types.
package pdp8_pkg;

    localparam int ADDR_WIDTH     = 12;
    localparam int DATA_WIDTH     = 12;
    localparam int IFU_RD_LATENCY = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } ifu_state_t;

endpackage

// File: rtl/ifu_fetch_ctrl_if.sv
// Fetch-side buses: the memory read port and the instruction hand-off to the decoder.
interface ifu_fetch_ctrl_if;
    import pdp8_pkg::*;

    logic                  ifu_rd_req;
    logic [ADDR_WIDTH-1:0] ifu_rd_addr;
    logic [DATA_WIDTH-1:0] ifu_rd_data;
    logic                  ifu_valid;
    logic [DATA_WIDTH-1:0] ifu_instr;
    logic [ADDR_WIDTH-1:0] ifu_pc;
    logic                  dec_ready;

    modport master (
        output ifu_rd_req, ifu_rd_addr, ifu_valid, ifu_instr, ifu_pc,
        input  ifu_rd_data, dec_ready
    );

    modport slave (
        input  ifu_rd_req, ifu_rd_addr, ifu_valid, ifu_instr, ifu_pc,
        output ifu_rd_data, dec_ready
    );

endinterface

// File: rtl/ifu_fetch_ctrl.sv
// Instruction fetch controller: one read per instruction, fixed read latency,
// valid/ready hand-off to the decoder and PC redirects from execute.
module ifu_fetch_ctrl
    import pdp8_pkg::*;
#(
    parameter int RD_LATENCY = IFU_RD_LATENCY
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic                  halt,
    input  logic                  exe_redirect,
    input  logic [ADDR_WIDTH-1:0] exe_target,
    ifu_fetch_ctrl_if.master      bus
);

    localparam int              CNT_W    = $clog2(RD_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY - 1);

    ifu_state_t            state, state_nxt;
    logic [ADDR_WIDTH-1:0] pc, pc_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic                  discard, discard_nxt;
    logic                  valid_q, valid_nxt;
    logic [DATA_WIDTH-1:0] instr_q, instr_nxt;
    logic [ADDR_WIDTH-1:0] ipc_q, ipc_nxt;
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;

    logic rd_done;
    logic drop;
    logic handshake;

    assign rd_done   = (cnt == '0);
    // A redirect landing on the data-return cycle drops that data as well.
    assign drop      = discard | exe_redirect;
    assign handshake = valid_q & bus.dec_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pc      <= '0;
            cnt     <= '0;
            discard <= 1'b0;
            valid_q <= 1'b0;
            instr_q <= '0;
            ipc_q   <= '0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            cnt     <= cnt_nxt;
            discard <= discard_nxt;
            valid_q <= valid_nxt;
            instr_q <= instr_nxt;
            ipc_q   <= ipc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start && !halt) state_nxt = REQ;
            REQ:  state_nxt = WAIT;
            WAIT: if (rd_done) state_nxt = drop ? REQ : HOLD;
            HOLD: begin
                if (exe_redirect)   state_nxt = REQ;
                else if (handshake) state_nxt = halt ? IDLE : REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pc_nxt      = pc;
        cnt_nxt     = cnt;
        discard_nxt = discard;
        valid_nxt   = valid_q;
        instr_nxt   = instr_q;
        ipc_nxt     = ipc_q;
        rd_req      = 1'b0;
        rd_addr     = '0;
        case (state)
            IDLE: begin
                if (start && !halt) pc_nxt = start_addr;
            end
            REQ: begin
                rd_req  = 1'b1;
                rd_addr = pc;
                cnt_nxt = CNT_LOAD;
                if (exe_redirect) begin
                    pc_nxt      = exe_target;
                    discard_nxt = 1'b1;
                end
            end
            WAIT: begin
                if (!rd_done) cnt_nxt = cnt - 1'b1;
                if (exe_redirect) pc_nxt = exe_target;
                if (rd_done) begin
                    if (drop) begin
                        discard_nxt = 1'b0;
                    end else begin
                        instr_nxt = bus.ifu_rd_data;
                        ipc_nxt   = pc;
                        valid_nxt = 1'b1;
                        pc_nxt    = pc + 1'b1;
                    end
                end else if (exe_redirect) begin
                    discard_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (exe_redirect) begin
                    valid_nxt = 1'b0;
                    pc_nxt    = exe_target;
                end else if (handshake) begin
                    valid_nxt = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign bus.ifu_rd_req  = rd_req;
    assign bus.ifu_rd_addr = rd_addr;
    assign bus.ifu_valid   = valid_q;
    assign bus.ifu_instr   = instr_q;
    assign bus.ifu_pc      = ipc_q;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Bench for ifu_fetch_ctrl: timestamp-based fetch model feeds expectation queues,
// a negedge monitor compares DUT outputs against them.
module tb_ifu_fetch_ctrl;
    import pdp8_pkg::*;

    localparam int LAT = 3;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef struct { int c; addr_t a; }           req_e;
    typedef struct { int c; word_t i; addr_t a; } val_e;

    logic  clk = 1'b0;
    logic  reset = 1'b1;
    logic  start = 1'b0;
    logic  halt = 1'b0;
    logic  exe_redirect = 1'b0;
    addr_t start_addr = '0;
    addr_t exe_target = '0;

    ifu_fetch_ctrl_if bus_if();

    ifu_fetch_ctrl #(.RD_LATENCY(LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .start_addr   (start_addr),
        .halt         (halt),
        .exe_redirect (exe_redirect),
        .exe_target   (exe_target),
        .bus          (bus_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0o want=%0o", nm, cyc, act, exp);
        end
    endtask

    // Memory: fixed contents, data for a request at cycle t shows up in cycle t+LAT.
    word_t mem [0:4095];
    bit    hv [0:LAT];
    addr_t ha [0:LAT];

    always @(negedge clk) begin
        for (int k = LAT; k > 0; k--) begin
            hv[k] = hv[k-1];
            ha[k] = ha[k-1];
        end
        hv[0] = bus_if.ifu_rd_req;
        ha[0] = bus_if.ifu_rd_addr;
        bus_if.ifu_rd_data = hv[LAT] ? mem[ha[LAT]] : word_t'($urandom);
    end

    // Expectation queues filled by the model.
    req_e exp_req[$];
    val_e exp_val[$];
    int   exp_end[$];
    int   exp_zero[$];

    // Model: tracks when the next request is due, the in-flight read and whether
    // anything has made it stale, and the instruction being offered.
    bit    m_active, m_holding, m_inflight, m_stale;
    int    m_req_at = -1;
    int    m_fetch_t;
    addr_t m_fetch_a;
    addr_t m_pc;

    task automatic model(input int c);
        if (m_req_at == c) begin
            exp_req.push_back('{c, m_pc});
            m_inflight = 1; m_fetch_t = c; m_fetch_a = m_pc; m_stale = 0; m_req_at = -1;
        end
        if (reset) begin
            if (m_holding) exp_end.push_back(c + 1);
            exp_zero.push_back(c + 1);
            m_active = 0; m_holding = 0; m_inflight = 0; m_stale = 0;
            m_req_at = -1; m_pc = '0;
        end else if (m_holding) begin
            if (exe_redirect) begin
                exp_end.push_back(c + 1);
                m_holding = 0; m_pc = exe_target; m_req_at = c + 1;
            end else if (bus_if.dec_ready) begin
                exp_end.push_back(c + 1);
                m_holding = 0;
                if (halt) m_active = 0;
                else      m_req_at = c + 1;
            end
        end else if (m_inflight) begin
            if (exe_redirect) begin
                m_pc = exe_target; m_stale = 1;
            end
            if (c == m_fetch_t + LAT) begin
                m_inflight = 0;
                if (m_stale) m_req_at = c + 1;
                else begin
                    exp_val.push_back('{c + 1, mem[m_fetch_a], m_fetch_a});
                    m_holding = 1;
                    m_pc = m_fetch_a + 1'b1;
                end
            end
        end else if (!m_active) begin
            if (start && !halt) begin
                m_active = 1; m_pc = start_addr; m_req_at = c + 1;
            end
        end
    endtask

    task automatic step(input bit r, input bit st, input addr_t sa, input bit h,
                        input bit rd, input addr_t tg, input bit rdy);
        @(posedge clk); #1;
        reset = r; start = st; start_addr = sa; halt = h;
        exe_redirect = rd; exe_target = tg; bus_if.dec_ready = rdy;
        model(cyc);
    endtask

    task automatic idle_step(input bit rdy);
        step(0, 0, '0, 0, 0, '0, rdy);
    endtask

    task automatic wait_hold();
        int n = 0;
        while (!m_holding && n < 64) begin idle_step(0); n++; end
        chk("reach_hold", 32'(m_holding), 1);
    endtask

    task automatic wait_mid_wait();
        int n = 0;
        while (!(m_inflight && cyc == m_fetch_t + 1) && n < 64) begin idle_step(0); n++; end
        chk("reach_wait", 32'(m_inflight && cyc == m_fetch_t + 1), 1);
    endtask

    // Monitor
    bit    mon_hold;
    word_t hold_i;
    addr_t hold_a;

    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (exp_req.size() > 0 && exp_req[0].c == cyc) begin
                chk("req_fire", 32'(bus_if.ifu_rd_req), 1);
                chk("req_addr", 32'(bus_if.ifu_rd_addr), 32'(exp_req[0].a));
                void'(exp_req.pop_front());
            end else begin
                chk("req_quiet", 32'(bus_if.ifu_rd_req), 0);
            end

            if (exp_val.size() > 0 && exp_val[0].c == cyc) begin
                chk("valid_rise", 32'(bus_if.ifu_valid), 1);
                chk("instr", 32'(bus_if.ifu_instr), 32'(exp_val[0].i));
                chk("pc", 32'(bus_if.ifu_pc), 32'(exp_val[0].a));
                hold_i = exp_val[0].i; hold_a = exp_val[0].a; mon_hold = 1;
                void'(exp_val.pop_front());
            end else if (exp_end.size() > 0 && exp_end[0] == cyc) begin
                chk("valid_drop", 32'(bus_if.ifu_valid), 0);
                mon_hold = 0;
                void'(exp_end.pop_front());
            end else if (mon_hold) begin
                chk("valid_hold", 32'(bus_if.ifu_valid), 1);
                chk("instr_hold", 32'(bus_if.ifu_instr), 32'(hold_i));
                chk("pc_hold", 32'(bus_if.ifu_pc), 32'(hold_a));
            end else begin
                chk("valid_quiet", 32'(bus_if.ifu_valid), 0);
            end

            if (exp_zero.size() > 0 && exp_zero[0] == cyc) begin
                chk("rst_instr", 32'(bus_if.ifu_instr), 0);
                chk("rst_pc", 32'(bus_if.ifu_pc), 0);
                chk("rst_addr", 32'(bus_if.ifu_rd_addr), 0);
                void'(exp_zero.pop_front());
            end
        end
    end

    initial begin
        bit    r, st, h, rd, rdy;
        addr_t sa, tg;

        for (int k = 0; k < 4096; k++) mem[k] = word_t'($urandom);
        mem[12'o200] = 12'o7200;
        bus_if.dec_ready   = 1'b0;
        bus_if.ifu_rd_data = '0;

        repeat (3) step(1, 0, '0, 0, 0, '0, 0);

        // First fetch from 0o200, decoder slow to accept.
        step(0, 1, 12'o200, 0, 0, '0, 0);
        wait_hold();
        idle_step(0);
        idle_step(1);

        // Stall in HOLD for five cycles, then accept.
        wait_hold();
        repeat (5) idle_step(0);
        idle_step(1);

        // Stop, then run across the address wrap with the decoder always ready.
        wait_hold();
        step(0, 0, '0, 1, 0, '0, 1);
        idle_step(0);
        step(0, 1, 12'o7776, 0, 0, '0, 1);
        repeat (4 * (LAT + 2)) idle_step(1);

        // Redirect while the read is outstanding.
        wait_mid_wait();
        step(0, 0, '0, 0, 1, 12'o400, 0);
        wait_hold();
        idle_step(1);

        // Redirect together with a handshake, then halt at a handshake.
        wait_hold();
        step(0, 0, '0, 0, 1, 12'o1234, 1);
        wait_hold();
        step(0, 0, '0, 1, 0, '0, 1);
        repeat (6) step(0, 1, 12'o300, 1, 0, '0, 0);
        step(0, 1, 12'o300, 0, 0, '0, 0);

        // Reset in the middle of WAIT; the late data must never surface.
        wait_mid_wait();
        step(1, 0, '0, 0, 0, '0, 0);
        repeat (LAT + 3) idle_step(1);

        for (int i = 0; i < 2500; i++) begin
            r   = ($urandom_range(0, 99) == 0);
            st  = ($urandom_range(0, 3) == 0);
            h   = ($urandom_range(0, 7) == 0);
            rd  = ($urandom_range(0, 9) == 0);
            rdy = 1'($urandom_range(0, 1));
            sa  = ($urandom_range(0, 3) == 0) ? addr_t'(12'o7774 + $urandom_range(0, 3))
                                             : addr_t'($urandom);
            tg  = addr_t'($urandom);
            step(r, st, sa, h, rd, tg, rdy);
        end

        repeat (3 * LAT + 10) step(0, 0, '0, 1, 0, '0, 1);
        @(negedge clk);
        @(negedge clk);
        chk("drain_req", 32'(exp_req.size()), 0);
        chk("drain_val", 32'(exp_val.size()), 0);
        chk("drain_end", 32'(exp_end.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifu_fetch_ctrl.md
# ifu_fetch_ctrl

Instruction fetch controller for the PDP-8 core. It is the requesting side of the IFU memory read interface (`ifu_rd_req` / `ifu_rd_addr` / `ifu_rd_data`): it holds the program counter, issues one read per instruction, and captures the returned 12-bit word after a fixed read latency. It presents the instruction and its address to the decoder over a valid/ready handshake, and accepts PC redirects from execute.

## Interface
- `RD_LATENCY`, default 1: cycles from the `ifu_rd_req` cycle to the cycle in which `ifu_rd_data` is valid; must be ≥1.
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  pulse; begin fetching at `start_addr`. Honoured only in IDLE.
- `start_addr`  in  `ADDR_WIDTH`  initial PC.
- `halt`  in  1  stop after the current handshake, or in IDLE block `start`.
- `exe_redirect`  in  1  pulse; replace the PC with `exe_target`.
- `exe_target`  in  `ADDR_WIDTH`  redirect address.
- `ifu_rd_req`  out  1  one-cycle read request.
- `ifu_rd_addr`  out  `ADDR_WIDTH`  read address; valid while `ifu_rd_req` is high.
- `ifu_rd_data`  in  `DATA_WIDTH`  read data from memory.
- `ifu_valid`  out  1  the instruction outputs are valid.
- `ifu_instr`  out  `DATA_WIDTH`  fetched instruction word.
- `ifu_pc`  out  `ADDR_WIDTH`  address the instruction was fetched from.
- `dec_ready`  in  1  the decoder accepts the instruction.

## Operation
- States: IDLE, REQ, WAIT, HOLD.
- **Reset:** state goes to IDLE. `pc`, `ifu_rd_req`, `ifu_rd_addr`, `ifu_valid`, `ifu_instr`, `ifu_pc`, the latency counter and `discard` all go to 0. Reset has priority over every other input in every state.
- **IDLE:** if `start` is high and `halt` is low, load `pc` from `start_addr` and go to REQ.
- **REQ:** drive `ifu_rd_req`=1 and `ifu_rd_addr`=`pc` for exactly one cycle. Load the counter with `RD_LATENCY`-1. Go to WAIT.
- **WAIT:** decrement the counter each cycle.
  - When the counter is 0, sample `ifu_rd_data`.
  - If `discard`=0: set `ifu_instr` to the sampled data, `ifu_pc` to `pc`, `ifu_valid` to 1, increment `pc`, and go to HOLD.
  - If `discard`=1: clear `discard` and go to REQ. No valid is produced.
- **HOLD:** hold `ifu_valid`, `ifu_instr` and `ifu_pc` stable until `ifu_valid & dec_ready`.
  - On the handshake, clear `ifu_valid`.
  - Then go to IDLE if `halt` is high, otherwise go to REQ.
- **Redirect:**
  - In REQ or WAIT: `pc` takes `exe_target` and `discard` is set. The outstanding read still completes, but its data is dropped.
  - In HOLD: clear `ifu_valid`, `pc` takes `exe_target`, go to REQ. Redirect wins over a simultaneous handshake; the held instruction counts as not consumed.
  - In IDLE: ignored.
- **Arithmetic:** `pc` increments modulo 2^`ADDR_WIDTH`, so 0o7777 wraps to 0o0000 with no flag.
- There is only ever one read outstanding. No new request is issued while in WAIT or HOLD.

## Timing
- Let REQ occupy cycle t.
  - `ifu_rd_data` is sampled at the end of cycle t+`RD_LATENCY`.
  - `ifu_valid` is first high in cycle t+`RD_LATENCY`+1.
- Cycles per instruction with `dec_ready` held high is `RD_LATENCY`+2. With `RD_LATENCY`=1 that is 3: REQ, WAIT, HOLD.
- From `start` sampled high, the first `ifu_rd_req` is in the next cycle.
- From a redirect accepted in HOLD, the request to `exe_target` is in the next cycle.
- A redirect in WAIT costs one extra full read. The counter width is $clog2(`RD_LATENCY`+1).
- Reset asserted in any cycle gives all outputs at 0 in the following cycle. Any in-flight read data is ignored.

## Structure
- `pdp8_pkg` additions:
  - `ifu_state_t`: enum of IDLE, REQ, WAIT, HOLD.
  - `IFU_RD_LATENCY` constant, used as the parameter default.
- `ADDR_WIDTH` and `DATA_WIDTH` are already defined in `pdp8_pkg` and are used unchanged.
- Single flat module with no sub-module. The latency counter, PC and output registers stay inline.

## Test plan
1. Reset, then `start` with `start_addr`=0o200 and memory returning 0o7200 → one request at addr 0o200, then `ifu_valid` with `ifu_instr`=0o7200 and `ifu_pc`=0o200, exactly 2 cycles after the request (`RD_LATENCY`=1).
2. `start_addr`=0o7776, `dec_ready`=1, four fetches → request addresses 0o7776, 0o7777, 0o0000, 0o0001 on a 3-cycle cadence.
3. `dec_ready` held low for 5 cycles in HOLD → `ifu_instr`/`ifu_pc` stable, `ifu_valid` stays high, no `ifu_rd_req`. Then `dec_ready`=1 → the next request comes 1 cycle later.
4. `exe_redirect` with target 0o400 during WAIT → no `ifu_valid` for the old fetch, next request addr 0o400, next `ifu_pc`=0o400.
5. `exe_redirect` and `dec_ready` in the same HOLD cycle → valid drops, next request addr = target. `halt` at a handshake → IDLE with no further requests, and `start` is ignored while `halt` stays high.
6. `reset` pulsed in the middle of WAIT (`RD_LATENCY`=3) → the next cycle shows all outputs 0 and IDLE, and late read data never appears on `ifu_instr`.
